// File: rtl/clkgen_ctrl.sv
// Programmable divided-clock generator: period/high/phase config over valid/ready,
// start-up phase delay, registered glitch-free clk_out, reconfiguration at period boundaries.
module clkgen_ctrl #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [CNT_W-1:0] cfg_period,
  input  logic [CNT_W-1:0] cfg_high,
  input  logic [CNT_W-1:0] cfg_phase,
  input  logic             enable,
  output logic             clk_out,
  output logic             period_start,
  output logic             busy,
  output logic             cfg_err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PHASE = 2'd1,
    RUN   = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] TWO = CNT_W'(2);

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [CNT_W-1:0] pcnt, pcnt_n;
  logic [CNT_W-1:0] act_period, act_high, act_phase;
  logic [CNT_W-1:0] sh_period, sh_high, sh_phase;
  logic [CNT_W-1:0] high_n;
  logic             has_cfg, pending;
  logic             accept, cfg_ok, boundary, apply;
  logic             clk_out_n, period_start_n;

  assign cfg_ready = !pending;
  assign busy      = (state != IDLE);
  assign accept    = cfg_valid && cfg_ready;
  assign cfg_ok    = (cfg_period >= TWO) && (cfg_high != '0) && (cfg_high < cfg_period);

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    pcnt_n   = pcnt;
    boundary = 1'b0;
    case (state)
      IDLE: begin
        if (enable && has_cfg) begin
          if (act_phase != '0) begin
            state_n = PHASE;
            pcnt_n  = '0;
          end else begin
            state_n = RUN;
            cnt_n   = '0;
          end
        end
      end
      PHASE: begin
        // An aborted start also counts as a boundary so a staged config cannot stall ready.
        if (!enable) begin
          state_n  = IDLE;
          boundary = 1'b1;
        end else if (pcnt == act_phase - ONE) begin
          state_n  = RUN;
          cnt_n    = '0;
          boundary = 1'b1;
        end else begin
          pcnt_n = pcnt + ONE;
        end
      end
      RUN: begin
        if (cnt == act_period - ONE) begin
          cnt_n    = '0;
          boundary = 1'b1;
          if (!enable) state_n = IDLE;
        end else begin
          cnt_n = cnt + ONE;
        end
      end
      default: state_n = IDLE;
    endcase

    apply          = boundary && pending;
    high_n         = apply ? sh_high : act_high;
    clk_out_n      = (state_n == RUN) && (cnt_n < high_n);
    period_start_n = (state_n == RUN) && (cnt_n == '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= '0;
      pcnt         <= '0;
      act_period   <= '0;
      act_high     <= '0;
      act_phase    <= '0;
      sh_period    <= '0;
      sh_high      <= '0;
      sh_phase     <= '0;
      has_cfg      <= 1'b0;
      pending      <= 1'b0;
      clk_out      <= 1'b0;
      period_start <= 1'b0;
      cfg_err      <= 1'b0;
    end else begin
      state        <= state_n;
      cnt          <= cnt_n;
      pcnt         <= pcnt_n;
      clk_out      <= clk_out_n;
      period_start <= period_start_n;
      cfg_err      <= accept && !cfg_ok;
      if (apply) begin
        act_period <= sh_period;
        act_high   <= sh_high;
        act_phase  <= sh_phase;
        pending    <= 1'b0;
      end
      // pending is 0 whenever accept is possible, so staging never collides with apply.
      if (accept && cfg_ok) begin
        if (state == IDLE) begin
          act_period <= cfg_period;
          act_high   <= cfg_high;
          act_phase  <= cfg_phase;
          has_cfg    <= 1'b1;
        end else begin
          sh_period <= cfg_period;
          sh_high   <= cfg_high;
          sh_phase  <= cfg_phase;
          pending   <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_clkgen_ctrl.sv
// Self-checking bench for clkgen_ctrl: table of configs plus hand-written staging/stop/reset sequences.
module tb_clkgen_ctrl;
  localparam int unsigned CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic             cfg_valid;
  logic             cfg_ready;
  logic [CNT_W-1:0] cfg_period, cfg_high, cfg_phase;
  logic             enable;
  logic             clk_out, period_start, busy, cfg_err;

  clkgen_ctrl #(.CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .cfg_valid   (cfg_valid),
    .cfg_ready   (cfg_ready),
    .cfg_period  (cfg_period),
    .cfg_high    (cfg_high),
    .cfg_phase   (cfg_phase),
    .enable      (enable),
    .clk_out     (clk_out),
    .period_start(period_start),
    .busy        (busy),
    .cfg_err     (cfg_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    string tag;
    logic  co, ps, bz, rdy, err;
  } exp_t;

  typedef struct {
    int unsigned period, high, phase;
    bit          ok;
    int unsigned ncyc;
  } vec_t;

  exp_t sbq[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic chk(input string name, input logic act, input logic req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%b required=%b at %0t", name, act, req, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input string tag, input logic co, input logic ps, input logic bz,
                      input logic rdy, input logic err);
    exp_t e;
    e.tag = tag; e.co = co; e.ps = ps; e.bz = bz; e.rdy = rdy; e.err = err;
    sbq.push_back(e);
  endtask

  // Advance one cycle and compare the DUT against the oldest expectation.
  task automatic step();
    exp_t e;
    tick();
    if (sbq.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL scoreboard_empty actual=0 required=1 at %0t", $time);
    end else begin
      e = sbq.pop_front();
      chk({e.tag, ".clk_out"}, clk_out, e.co);
      chk({e.tag, ".period_start"}, period_start, e.ps);
      chk({e.tag, ".busy"}, busy, e.bz);
      chk({e.tag, ".cfg_ready"}, cfg_ready, e.rdy);
      chk({e.tag, ".cfg_err"}, cfg_err, e.err);
    end
  endtask

  task automatic do_reset(input string tag);
    cfg_valid = 1'b0;
    enable    = 1'b0;
    rst       = 1'b1;
    #1;
    chk({tag, ".rst.clk_out"}, clk_out, 1'b0);
    chk({tag, ".rst.period_start"}, period_start, 1'b0);
    chk({tag, ".rst.busy"}, busy, 1'b0);
    chk({tag, ".rst.cfg_ready"}, cfg_ready, 1'b1);
    chk({tag, ".rst.cfg_err"}, cfg_err, 1'b0);
    tick();
    rst = 1'b0;
  endtask

  task automatic write_cfg(input string tag, input int unsigned p, input int unsigned h,
                           input int unsigned ph, input bit ok);
    cfg_period = CNT_W'(p);
    cfg_high   = CNT_W'(h);
    cfg_phase  = CNT_W'(ph);
    cfg_valid  = 1'b1;
    push({tag, ".cfg"}, 1'b0, 1'b0, 1'b0, 1'b1, !ok);
    step();
    cfg_valid = 1'b0;
  endtask

  vec_t vecs[7];

  initial begin
    int unsigned j, m;
    logic        co, ps, bz, rdy;

    rst        = 1'b1;
    cfg_valid  = 1'b0;
    enable     = 1'b0;
    cfg_period = '0;
    cfg_high   = '0;
    cfg_phase  = '0;

    vecs[0] = '{period: 10, high: 4,  phase: 0, ok: 1'b1, ncyc: 25};
    vecs[1] = '{period: 10, high: 4,  phase: 3, ok: 1'b1, ncyc: 25};
    vecs[2] = '{period: 10, high: 10, phase: 0, ok: 1'b0, ncyc: 12};
    vecs[3] = '{period: 1,  high: 0,  phase: 0, ok: 1'b0, ncyc: 12};
    vecs[4] = '{period: 2,  high: 1,  phase: 0, ok: 1'b1, ncyc: 12};
    vecs[5] = '{period: 5,  high: 4,  phase: 1, ok: 1'b1, ncyc: 16};
    vecs[6] = '{period: 5,  high: 0,  phase: 2, ok: 1'b0, ncyc: 10};

    for (int unsigned v = 0; v < 7; v++) begin
      string tag;
      tag = $sformatf("vec%0d", v);
      do_reset(tag);
      write_cfg(tag, vecs[v].period, vecs[v].high, vecs[v].phase, vecs[v].ok);
      enable = 1'b1;
      for (int unsigned k = 1; k <= vecs[v].ncyc; k++) begin
        co = 1'b0; ps = 1'b0; bz = 1'b0;
        if (vecs[v].ok) begin
          bz = 1'b1;
          if (k > vecs[v].phase) begin
            j  = k - vecs[v].phase - 1;
            m  = j % vecs[v].period;
            co = (m < vecs[v].high);
            ps = (m == 0);
          end
        end
        push($sformatf("%s.k%0d", tag, k), co, ps, bz, 1'b1, 1'b0);
        step();
      end
    end

    // Stage 6/3/0 while running 10/4 at cnt=2; it takes over at the next wrap.
    do_reset("stage");
    write_cfg("stage", 10, 4, 0, 1'b1);
    enable = 1'b1;
    for (int unsigned k = 1; k <= 30; k++) begin
      if (k == 4) begin
        cfg_period = CNT_W'(6);
        cfg_high   = CNT_W'(3);
        cfg_phase  = '0;
        cfg_valid  = 1'b1;
      end
      if (k == 5) cfg_valid = 1'b0;
      if (k <= 10) begin
        co = (k - 1 < 4);
        ps = (k == 1);
      end else begin
        m  = (k - 11) % 6;
        co = (m < 3);
        ps = (m == 0);
      end
      rdy = !(k >= 4 && k <= 10);
      push($sformatf("stage.k%0d", k), co, ps, 1'b1, rdy, 1'b0);
      step();
    end

    // Drop enable at cnt=1: the period runs out to cnt=9 and then the block idles.
    do_reset("stop");
    write_cfg("stop", 10, 4, 0, 1'b1);
    enable = 1'b1;
    for (int unsigned k = 1; k <= 15; k++) begin
      if (k == 3) enable = 1'b0;
      co = (k <= 10) && (k - 1 < 4);
      ps = (k == 1);
      bz = (k <= 10);
      push($sformatf("stop.k%0d", k), co, ps, bz, 1'b1, 1'b0);
      step();
    end

    // Asynchronous reset during a high cycle, then enable with no config stays idle.
    do_reset("arst");
    write_cfg("arst", 10, 4, 0, 1'b1);
    enable = 1'b1;
    push("arst.k1", 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    step();
    push("arst.k2", 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    step();
    rst = 1'b1;
    #1;
    chk("arst.async.clk_out", clk_out, 1'b0);
    chk("arst.async.busy", busy, 1'b0);
    chk("arst.async.cfg_ready", cfg_ready, 1'b1);
    chk("arst.async.period_start", period_start, 1'b0);
    tick();
    rst = 1'b0;
    for (int unsigned k = 1; k <= 6; k++) begin
      push($sformatf("arst.post%0d", k), 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      step();
    end
    enable = 1'b0;

    if (sbq.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL scoreboard_leftover actual=%0d required=0", sbq.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/clkgen_ctrl.md
# clkgen_ctrl

Programmable divided-clock/waveform generator controller. It is the synthesizable counterpart of the bench-side frequency/duty/phase clock task. It accepts a period, high-time and phase offset in `clk` cycles over a valid/ready config port, sequences the start-up phase delay and emits a registered, glitch-free `clk_out`. Mid-run reconfiguration takes effect only at a period boundary. It sits between the register/config layer and any logic needing a derived strobe or enable clock.

## Interface
- `CNT_W`, 16, width of the period/high/phase fields and internal counters
- `clk`  in  1  system clock, all logic on its rising edge
- `rst`  in  1  asynchronous, active-high reset
- `cfg_valid`  in  1  config request
- `cfg_ready`  out  1  config can be accepted this cycle
- `cfg_period`  in  CNT_W  output period in `clk` cycles
- `cfg_high`  in  CNT_W  high cycles per period
- `cfg_phase`  in  CNT_W  low cycles inserted between start and the first period
- `enable`  in  1  run request (level)
- `clk_out`  out  1  generated waveform, registered
- `period_start`  out  1  high during the first cycle of every period (cnt==0)
- `busy`  out  1  state != IDLE
- `cfg_err`  out  1  one-cycle pulse when an accepted config is rejected as invalid

## Operation
- **Handshake.** A config transfers on an edge with `cfg_valid && cfg_ready`. `cfg_ready` = !pending.
- **Validity.** A config is valid iff `period>=2`, `high>=1` and `high<period`, all unsigned CNT_W compares.
  - Invalid config: the handshake still completes, `cfg_err` pulses on the next cycle, and the config is discarded with no state change.
- **Config storage:**
  - Accepted in IDLE: written directly to the active registers; sets `has_cfg`.
  - Accepted in PHASE or RUN: written to a shadow register; sets `pending`.
  - The shadow is applied (active<=shadow, pending<=0) on the PHASE->RUN edge or the wrap edge (cnt==period-1).
  - A config accepted on a boundary edge is staged, not applied at that boundary.
- **Phase field.** Used only on IDLE->start. The phase of a staged config is stored but takes effect only on the next start.
- **FSM:**
  - IDLE: `clk_out`=0. On `enable && has_cfg`, go to PHASE (pcnt<=0) if phase!=0, otherwise go to RUN (cnt<=0). `enable` without `has_cfg` stays in IDLE.
  - PHASE: `clk_out`=0 and pcnt increments. When pcnt==phase-1, go to RUN with cnt=0. If `enable` is low, return to IDLE immediately.
  - RUN: cnt counts 0..period-1 and wraps to 0. `clk_out`=1 exactly during cycles with cnt<high. At the wrap edge, go to IDLE if `enable` is low, otherwise continue. The shadow is applied at that edge in either case.
- **Output behaviour.** A high pulse is never truncated, and a period is never cut short except by `rst`. The counter never wraps at 2^CNT_W; the maximum period is 2^CNT_W-1.

## Timing
- **Reset values:** state=IDLE, `clk_out`=0, `period_start`=0, `cfg_ready`=1, `busy`=0, `cfg_err`=0. `has_cfg`, `pending`, counters and active/shadow registers are all 0.
- **Mid-operation reset.** `rst` forces all outputs to their reset values asynchronously, and all config is lost.
- **Start, phase=0.** With `enable` sampled high in IDLE at edge E0, `clk_out` rises and `period_start` is high in the cycle after E0 (latency 1).
- **Start, phase=P.** `busy` rises after E0. `clk_out` stays low for P cycles, then rises P+1 cycles after E0.
- **`period_start`.** One cycle wide, coincident with the first high cycle of each period.
- **`cfg_err`.** Asserted in the cycle after the accepting edge, for exactly one cycle.
- **`cfg_ready` while staged.** Low from the cycle after staging until the cycle after the applying boundary.
- **Stop.** `busy` falls in the cycle after the final wrap edge.

## Test plan
- Reset; config 10/4/0; `enable`=1 → `clk_out` repeats 4 high then 6 low. `period_start` every 10 cycles. First high 1 cycle after the enable edge.
- Config 10/4/3 → `clk_out` low for 3 cycles after the enable edge, first rise 4 cycles after it, `busy` high from cycle 1.
- In RUN with 10/4, stage 6/3/0 at cnt=2 → the current 10-cycle period completes unchanged, subsequent periods are 3 high/3 low, and `cfg_ready` is low from staging until the cycle after the boundary.
- Config 10/10/0, then 1/0/0 → each gives a `cfg_err` one-cycle pulse, `has_cfg` stays 0, and `enable` produces no activity (`busy`=0).
- RUN 10/4; drop `enable` at cnt=1 → period finishes through cnt=9, `busy` falls in the cycle after, and `clk_out` stays 0.
- Assert `rst` during a high cycle → `clk_out`=0 immediately. After release, `enable` alone with no new config keeps the block in IDLE.
